// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer sequencer: timer register map, CTRL bits,
// FSM state encoding and the fixed per-tick overhead.
package timer_seq_pkg;

    localparam logic [3:0] REG_CTRL  = 4'h0;
    localparam logic [3:0] REG_VALUE = 4'h8;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEND = 2;

    // Cycles per tick spent outside counting: WR_EN, WAIT detect, CLEAR, TICK,
    // plus the expiry cycle itself (VALUE = P - 5 gives V + 1 counting cycles).
    localparam logic [31:0] MIN_PERIOD = 32'd5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR_VAL = 3'd1;
    localparam logic [2:0] ST_WR_EN  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;
    localparam logic [2:0] ST_TICK   = 3'd5;
    localparam logic [2:0] ST_ABORT  = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        WR_VAL = ST_WR_VAL,
        WR_EN  = ST_WR_EN,
        WAIT   = ST_WAIT,
        CLEAR  = ST_CLEAR,
        TICK   = ST_TICK,
        ABORT  = ST_ABORT
    } state_t;

endpackage

// File: rtl/timer_seq.sv
// Drives the count-up timer's register port to turn one (period, count)
// command into evenly spaced single-cycle tick pulses.
module timer_seq
    import timer_seq_pkg::*;
#(
    parameter logic [31:0] TMR_BASE = 32'h0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_period_i,
    input  logic [CNT_W-1:0] req_count_i,
    input  logic             abort_i,
    output logic             tick_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [31:0]      tmr_addr_o,
    output logic [31:0]      tmr_data_o,
    output logic             tmr_we_o,
    input  logic [31:0]      tmr_data_i
);

    state_t           state, state_nxt;
    logic [31:0]      period;
    logic [CNT_W-1:0] rem;
    logic             cont;
    logic             accept;
    logic             last;

    assign accept = req_valid_i && req_ready_o;
    assign last   = !cont && (rem == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            period <= MIN_PERIOD;
            rem    <= '0;
            cont   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                period <= (req_period_i < MIN_PERIOD) ? MIN_PERIOD : req_period_i;
                rem    <= req_count_i;
                cont   <= (req_count_i == '0);
            end
            if (state == TICK && !abort_i && !cont && !last)
                rem <= rem - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        tick_o      = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state != IDLE);
        tmr_addr_o  = TMR_BASE | {28'b0, REG_CTRL};
        tmr_data_o  = '0;
        tmr_we_o    = 1'b0;

        case (state)
            IDLE: begin
                req_ready_o = !abort_i && !rst;
                if (accept) state_nxt = WR_VAL;
            end
            WR_VAL: begin
                tmr_addr_o = TMR_BASE | {28'b0, REG_VALUE};
                tmr_data_o = period - MIN_PERIOD;
                tmr_we_o   = 1'b1;
                state_nxt  = WR_EN;
            end
            WR_EN: begin
                tmr_data_o[CTRL_EN] = 1'b1;
                tmr_we_o            = 1'b1;
                state_nxt           = WAIT;
            end
            WAIT: begin
                if (tmr_data_i[CTRL_PEND]) state_nxt = CLEAR;
            end
            CLEAR: begin
                tmr_data_o[CTRL_PEND] = 1'b1;
                tmr_we_o              = 1'b1;
                state_nxt             = TICK;
            end
            TICK: begin
                tick_o    = 1'b1;
                done_o    = last && !abort_i;
                state_nxt = last ? IDLE : WR_EN;
            end
            ABORT: begin
                tmr_data_o[CTRL_PEND] = 1'b1;
                tmr_we_o              = 1'b1;
                state_nxt             = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides every other transition once a sequence is running.
        if (state != IDLE && state != ABORT && abort_i) state_nxt = ABORT;
    end

endmodule

// File: tb/tb_timer_seq.sv
// Directed bench for timer_seq with a behavioural model of the count-up timer
// on the register port; tick/done times are checked against hand-derived cycles.
module tb_timer_seq;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_period = '0;
    logic [CNT_W-1:0] req_count = '0;
    logic             abort = 1'b0;
    logic             tick, done, busy;
    logic [31:0]      tmr_addr, tmr_data, tmr_rdata;
    logic             tmr_we;

    timer_seq #(.TMR_BASE(32'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_period_i(req_period), .req_count_i(req_count),
        .abort_i(abort), .tick_o(tick), .done_o(done), .busy_o(busy),
        .tmr_addr_o(tmr_addr), .tmr_data_o(tmr_data), .tmr_we_o(tmr_we),
        .tmr_data_i(tmr_rdata)
    );

    always #5 clk = ~clk;

    // Timer model: counts while enabled, expiry disables and sets pending
    // unless a register write lands in the same cycle.
    logic        t_en, t_ie, t_pend;
    logic [31:0] t_cnt, t_val;

    always_comb begin
        tmr_rdata = '0;
        if (tmr_addr[3:0] == 4'h0) tmr_rdata = {29'b0, t_pend, t_ie, t_en};
        else if (tmr_addr[3:0] == 4'h8) tmr_rdata = t_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_en <= 1'b0; t_ie <= 1'b0; t_pend <= 1'b0; t_cnt <= '0; t_val <= '0;
        end else if (tmr_we) begin
            if (tmr_addr[3:0] == 4'h0) begin
                t_en  <= tmr_data[0];
                t_ie  <= tmr_data[1];
                t_cnt <= '0;
                if (tmr_data[2]) t_pend <= 1'b0;
            end else if (tmr_addr[3:0] == 4'h8) begin
                t_val <= tmr_data;
            end
        end else if (t_en) begin
            if (t_cnt >= t_val) begin
                t_en <= 1'b0; t_pend <= 1'b1; t_cnt <= '0;
            end else begin
                t_cnt <= t_cnt + 32'd1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tick_q[$];
    int done_q[$];
    always @(negedge clk) begin
        if (tick) tick_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to cycle c, 1 time unit after its opening edge.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_accept(output int acc);
        int k;
        acc = -1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic [CNT_W-1:0] n, output int acc);
        req_valid = 1'b1; req_period = p; req_count = n;
        wait_accept(acc);
        req_valid = 1'b0;
    endtask

    task automatic clear_q();
        tick_q.delete();
        done_q.delete();
    endtask

    int a, a2;

    initial begin
        // reset state
        goto(3);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", tmr_we, 0);
        chk("rst_addr", tmr_addr, 0);
        chk("rst_data", tmr_data, 0);
        goto(4);
        rst = 1'b0;

        // period 10, count 3
        goto(100);
        clear_q();
        send(32'd10, 16'd3, a);
        chk("t1_accept", a, 100);
        goto(a + 40);
        chk("t1_ntick", tick_q.size(), 3);
        if (tick_q.size() == 3) begin
            chk("t1_tick0", tick_q[0], a + 11);
            chk("t1_tick1", tick_q[1], a + 21);
            chk("t1_tick2", tick_q[2], a + 31);
        end
        chk("t1_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("t1_done", done_q[0], a + 31);
        chk("t1_value", t_val, 5);
        chk("t1_idle", busy, 0);

        // period 2 clamps to 5
        clear_q();
        send(32'd2, 16'd2, a);
        goto(a + 2);
        chk("t2_value0", t_val, 0);
        goto(a + 20);
        chk("t2_ntick", tick_q.size(), 2);
        if (tick_q.size() == 2) begin
            chk("t2_tick0", tick_q[0], a + 6);
            chk("t2_tick1", tick_q[1], a + 11);
        end
        chk("t2_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("t2_done", done_q[0], a + 11);

        // continuous period 8, abort in the third WAIT
        clear_q();
        send(32'd8, 16'd0, a);
        goto(a + 20);
        abort = 1'b1;
        @(negedge clk);
        chk("t3_wait_busy", busy, 1);
        goto(a + 21);
        abort = 1'b0;
        @(negedge clk);
        chk("t3_abort_we", tmr_we, 1);
        chk("t3_abort_data", tmr_data, 4);
        chk("t3_abort_addr", tmr_addr, 0);
        chk("t3_abort_ready", req_ready, 0);
        goto(a + 22);
        @(negedge clk);
        chk("t3_ready", req_ready, 1);
        chk("t3_ctrl", tmr_rdata, 0);
        goto(a + 40);
        chk("t3_ntick", tick_q.size(), 2);
        if (tick_q.size() == 2) chk("t3_tick1", tick_q[1], a + 17);
        chk("t3_ndone", done_q.size(), 0);

        // continuous period 6, abort landing in TICK
        clear_q();
        send(32'd6, 16'd0, a);
        goto(a + 13);
        abort = 1'b1;
        @(negedge clk);
        chk("t4_tick", tick, 1);
        chk("t4_done", done, 0);
        goto(a + 14);
        abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_we", tmr_we, 1);
        chk("t4_abort_data", tmr_data, 4);
        goto(a + 15);
        @(negedge clk);
        chk("t4_ready", req_ready, 1);
        goto(a + 40);
        chk("t4_ntick", tick_q.size(), 2);
        chk("t4_ndone", done_q.size(), 0);

        // reset during WAIT, then period 6 count 1
        clear_q();
        send(32'd20, 16'd3, a);
        goto(a + 5);
        rst = 1'b1;
        goto(a + 6);
        @(negedge clk);
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_we", tmr_we, 0);
        chk("t5_rst_tick", tick, 0);
        chk("t5_rst_done", done, 0);
        goto(a + 7);
        rst = 1'b0;
        clear_q();
        send(32'd6, 16'd1, a);
        goto(a + 20);
        chk("t5_ntick", tick_q.size(), 1);
        if (tick_q.size() == 1) chk("t5_tick", tick_q[0], a + 7);
        chk("t5_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("t5_done", done_q[0], a + 7);

        // back-to-back commands, second held valid through the first
        clear_q();
        req_valid = 1'b1; req_period = 32'd7; req_count = 16'd2;
        wait_accept(a);
        req_period = 32'd12; req_count = 16'd2;
        wait_accept(a2);
        req_valid = 1'b0;
        chk("t6_accept2", a2, a + 16);
        goto(a2 + 40);
        chk("t6_ntick", tick_q.size(), 4);
        if (tick_q.size() == 4) begin
            chk("t6_tick0", tick_q[0], a + 8);
            chk("t6_tick1", tick_q[1], a + 15);
            chk("t6_tick2", tick_q[2], a2 + 13);
            chk("t6_tick3", tick_q[3], a2 + 25);
        end
        chk("t6_ndone", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("t6_done0", done_q[0], a + 15);
            chk("t6_done1", done_q[1], a2 + 25);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_seq.md
# timer_seq

Sequencer that owns the register port of the 32-bit count-up timer peripheral and turns a single command (period, tick count) into a train of evenly spaced one-cycle tick pulses. It programs the expiry value, enables the timer, polls the pending flag, clears it, and re-arms. This gives cores and DMA-style logic periodic or N-shot timing without software polling. It is the timer's only bus master and sits between the command source and the timer.

## Interface
- TMR_BASE, 32'h0: base address OR-ed into tmr_addr_o (timer decodes addr[3:0] only)
- CNT_W, 16: width of tick-count field
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid&ready
- req_period_i  in  32  tick spacing in clk cycles; values <5 treated as 5
- req_count_i  in  CNT_W  number of ticks; 0 = continuous until abort
- abort_i  in  1  stop current sequence (pulse)
- tick_o  out  1  one-cycle tick pulse
- done_o  out  1  one-cycle pulse with final tick of an N-shot sequence
- busy_o  out  1  high whenever state ≠ IDLE
- tmr_addr_o  out  32  timer register address
- tmr_data_o  out  32  timer write data
- tmr_we_o  out  1  timer write enable
- tmr_data_i  in  32  timer read data (combinational from tmr_addr_o)

## Operation
- Timer registers: CTRL 0x0 ([0] enable, [1] int enable, [2] pending, W1C), VALUE 0x8. The timer expires when count ≥ VALUE. It then clears enable and sets pending on the next edge, unless a write occurs in that cycle.
- States: IDLE, WR_VAL, WR_EN, WAIT, CLEAR, TICK, ABORT.
- IDLE: req_ready_o = ~abort_i. On accept, latch P = max(req_period_i, 5) and rem = req_count_i, set cont = (req_count_i == 0), then go to WR_VAL.
- WR_VAL: write VALUE = P − 5, then go to WR_EN.
- WR_EN: write CTRL = 0x1 (enable, interrupt disabled), then go to WAIT.
- WAIT: read CTRL with we = 0. When tmr_data_i[2] = 1, go to CLEAR.
- CLEAR: write CTRL = 0x4 to clear pending and keep the timer disabled, then go to TICK.
- TICK: tick_o = 1.
  - If cont, go to WR_EN.
  - Else if rem == 1, assert done_o and go to IDLE.
  - Else decrement rem and go to WR_EN.
- abort_i in any state other than IDLE goes to ABORT; abort takes priority over all other transitions. ABORT writes CTRL = 0x4, then goes to IDLE.
  - tick_o still pulses if abort_i arrives while in TICK.
  - done_o is never asserted for an aborted sequence.
- Idle bus value: tmr_addr_o = TMR_BASE|0x0, tmr_data_o = 0, tmr_we_o = 0.
- P − 5 is 32-bit unsigned and cannot underflow because of the clamp.

## Timing
- Reset: state IDLE; req_ready_o, tick_o, done_o, busy_o, tmr_we_o = 0; tmr_addr_o = TMR_BASE; tmr_data_o = 0; rem = 0. The timer resets on the same rst.
- Reset mid-sequence returns to IDLE the next cycle. No ABORT write is issued, because the timer is reset too.
- Accept at cycle a: first tick_o at cycle a + P + 1.
- Tick-to-tick spacing is exactly P cycles: V + 1 counting cycles, plus WAIT detect, CLEAR, TICK, and WR_EN, with V = P − 5.
- After ABORT: req_ready_o is high 2 cycles after the abort cycle. The timer count is guaranteed 0 before the next WR_EN.
- done_o coincides with the last tick_o. The next command can be accepted the cycle after done_o.
- All outputs come from registered state decode; there is no combinational path from req_*/abort_i to tmr_*.

## Structure
- Shared package/defines:
  - timer register offsets (REG_CTRL, REG_VALUE)
  - CTRL bit indices
  - the state encoding localparams
  - MIN_PERIOD = 5 (overhead constant)
- Single flat module with the FSM and its datapath (P, rem, cont registers). No sub-module.

## Test plan
- Period 10, count 3, accepted at cycle 100 -> tick_o at 111, 121, 131; done_o at 131; busy_o low from 132.
- Period 2 (clamped), count 2, accepted at 0 -> VALUE written as 0; ticks at 6 and 11; done_o at 11.
- Period 8, count 0 (continuous), abort_i during the third WAIT -> exactly 2 ticks; ABORT writes 0x4; timer CTRL reads 0; req_ready_o high 2 cycles after abort.
- abort_i asserted in TICK of a continuous run -> tick_o pulses that cycle, done_o stays 0, then ABORT, then IDLE.
- rst asserted during WAIT, then a new period-6 count-1 command -> all outputs 0 during reset; single tick at accept + 7 with done_o.
- Back-to-back: a second command held valid during the first -> accepted the cycle after done_o; its ticks are spaced by its own period.
